me_result_arb: RTL

Round-robin scheduler that shares the single bit-serial result output stage among N parallel motion-estimation processing lanes. Each lane deposits its (SAD, x, y) result into a one-entry holding slot. The arbiter issues one result at a time to the serializer as a one-cycle `en` pulse with parallel data, then holds off for the serializer's fixed shift time before issuing the next. It sits between the PE array's per-block best-match outputs and the result serializer.

---
 rtl/me_pkg.sv | 20 ++
 rtl/rr_pick.sv | 30 +++
 rtl/me_result_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared widths, default serializer time and types for the
// motion-estimation result path.
package me_pkg;

    localparam int SAD_W      = 14;
    localparam int MV_W       = 4;
    localparam int SER_CYCLES = 15;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [MV_W-1:0]  x;
        logic [MV_W-1:0]  y;
    } me_result_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, returns the first
// requester at or above ptr, wrapping around to index 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         any,
    output logic [W-1:0] sel
);

    import me_pkg::*;

    // scan from ptr upward, first hit wins
    always_comb begin
        int unsigned idx;
        idx = 0;
        any = 1'b0;
        sel = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any = 1'b1;
                sel = W'(idx);
            end
        end
    end

endmodule

// File: rtl/me_result_arb.sv
// me_result_arb: round-robin issue of per-lane ME results to the shared
// bit-serial result stage. Optional best-match tracker: ME_ARB_BEST_TRACK_EN.
module me_result_arb #(
    parameter int  N_LANE     = 4,
    parameter int  SAD_W      = me_pkg::SAD_W,
    parameter int  MV_W       = me_pkg::MV_W,
    parameter int  SER_CYCLES = me_pkg::SER_CYCLES,
    localparam int LW         = $clog2(N_LANE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_LANE-1:0]       lane_valid,
    output logic [N_LANE-1:0]       lane_ready,
    input  logic [N_LANE*SAD_W-1:0] lane_sad,
    input  logic [N_LANE*MV_W-1:0]  lane_x,
    input  logic [N_LANE*MV_W-1:0]  lane_y,
    output logic                    out_en,
    output logic [SAD_W-1:0]        out_sad,
    output logic [MV_W-1:0]         out_x,
    output logic [MV_W-1:0]         out_y,
    output logic [LW-1:0]           out_lane,
`ifdef ME_ARB_BEST_TRACK_EN
    input  logic                    frame_start,
    output logic [SAD_W-1:0]        best_sad,
    output logic [MV_W-1:0]         best_x,
    output logic [MV_W-1:0]         best_y,
    output logic [LW-1:0]           best_lane,
`endif
    output logic                    busy
);

    import me_pkg::*;

    localparam logic [5:0]    CNT_LOAD = 6'(SER_CYCLES - 1);
    localparam logic [LW-1:0] LAST     = LW'(N_LANE - 1);

    logic [N_LANE-1:0] full;
    logic [N_LANE-1:0] cap;
    logic [N_LANE-1:0] grant;
    logic [SAD_W-1:0]  s_sad [N_LANE];
    logic [MV_W-1:0]   s_x   [N_LANE];
    logic [MV_W-1:0]   s_y   [N_LANE];
    logic [LW-1:0]     rr_ptr;
    logic [LW-1:0]     sel;
    logic              any;
    logic              issue;
    logic [5:0]        cnt;
    arb_state_t        state;

    rr_pick #(.N(N_LANE), .W(LW)) u_pick (
        .req (full),
        .ptr (rr_ptr),
        .any (any),
        .sel (sel)
    );

    assign lane_ready = ~full;
    assign cap        = lane_valid & ~full;
    assign busy       = (state == HOLD);
    assign issue      = any && ((state == IDLE) || (cnt == 6'd0));

    // one-hot grant of the picked slot on an issue edge
    always_comb begin
        grant = '0;
        if (issue)
            grant[sel] = 1'b1;
    end

    // slot occupancy: set on capture, clear on grant (never the same lane)
    always_ff @(posedge clk) begin
        if (rst)
            full <= '0;
        else
            full <= (full | cap) & ~grant;
    end

    // slot payload latches on capture; contents are don't-care while empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANE; i++) begin
            if (cap[i]) begin
                s_sad[i] <= lane_sad[i*SAD_W +: SAD_W];
                s_x[i]   <= lane_x[i*MV_W +: MV_W];
                s_y[i]   <= lane_y[i*MV_W +: MV_W];
            end
        end
    end

    // issue FSM: pulse out_en, then hold off for the serializer shift time
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            out_en   <= 1'b0;
            out_sad  <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_lane <= '0;
        end else begin
            out_en <= issue;
            if (issue) begin
                out_sad  <= s_sad[sel];
                out_x    <= s_x[sel];
                out_y    <= s_y[sel];
                out_lane <= sel;
                rr_ptr   <= (sel == LAST) ? '0 : sel + 1'b1;
                cnt      <= CNT_LOAD;
                state    <= HOLD;
            end else if (state == HOLD) begin
                if (cnt != 6'd0)
                    cnt <= cnt - 6'd1;
                else
                    state <= IDLE;
            end
        end
    end

`ifdef ME_ARB_BEST_TRACK_EN
    // best-match tracker; a new frame takes a coincident issue as its first
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad  <= '1;
            best_x    <= '0;
            best_y    <= '0;
            best_lane <= '0;
        end else if (issue && (frame_start || s_sad[sel] < best_sad)) begin
            best_sad  <= s_sad[sel];
            best_x    <= s_x[sel];
            best_y    <= s_y[sel];
            best_lane <= sel;
        end else if (frame_start) begin
            best_sad  <= '1;
            best_x    <= '0;
            best_y    <= '0;
            best_lane <= '0;
        end
    end
`endif

endmodule
